n64_poll_sequencer: RTL and testbench
=====================================

Name: n64_poll_sequencer

Overview:
Periodic transaction controller for the N64 controller port. It owns the single-wire command writer: it issues the poll command byte, waits for the writer to finish, then receives and decodes the controller's 32-bit button/stick response from the same wire. It sits between the writer and the application logic. It presents the last good button word, a one-cycle valid strobe, and a one-cycle error strobe.

Parameters:
POLL_GAP, 16'd50000, idle cycles between the end of one transaction and the next command issue
POLL_CMD, 8'h01, command byte sent each transaction
BIT_CYCLES, 400, nominal line bit period in clk cycles (matches the writer's timing)
SAMPLE_POINT, 200, cycles after a detected falling edge at which the bit is sampled
RX_TIMEOUT, 16'd1200, max cycles waiting for a falling edge before the transaction aborts
BUSY_TIMEOUT, 8, max cycles after cmd_en for writer_busy to assert

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  polling permitted; sampled only in IDLE
cmd_byte  out  8  byte to the writer; held at POLL_CMD
cmd_en  out  1  one-cycle start pulse to the writer
writer_busy  in  1  writer transmitting (writer's writing_data)
line_in  in  1  wire level as read back from the pad
buttons  out  32  last valid response; first received bit is buttons[31]
buttons_valid  out  1  one-cycle pulse when buttons updates
rx_error  out  1  one-cycle pulse on any aborted transaction
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: buttons=0, buttons_valid=0, rx_error=0, cmd_en=0, busy=0, state=IDLE, gap counter=0, line_prev=1, bit count=0.
- Reset is synchronous and active-high. Asserting it mid-transaction returns the block to IDLE on the next edge; buttons are cleared.
- States:
  - IDLE: the gap counter increments while enable=1 and holds at 0 while enable=0. When the counter reaches POLL_GAP-1 and enable=1, the block goes to ISSUE and the counter clears.
  - ISSUE: cmd_en=1 for exactly this one cycle, then WAIT_BUSY.
  - WAIT_BUSY: on writer_busy=1, go to WAIT_DONE. If writer_busy stays 0 for BUSY_TIMEOUT cycles, pulse rx_error and go to IDLE.
  - WAIT_DONE: on writer_busy=0, go to RX_EDGE with the timeout counter and bit count at 0.
  - RX_EDGE: a falling edge (line_prev=1, line=0) moves the block to RX_SAMPLE with the phase counter at 0. If the timeout counter reaches RX_TIMEOUT, pulse rx_error, leave buttons unchanged, and go to IDLE.
  - RX_SAMPLE: the phase counter increments. At phase==SAMPLE_POINT, shift line into the shift register MSB-first and increment the bit count. If the bit count is now 32, go to DONE; otherwise return to RX_EDGE with the timeout counter cleared.
  - DONE: buttons<=shift register and buttons_valid=1 for one cycle, then IDLE. The controller stop bit is not checked.
- line_prev updates every cycle, including during the command phase. An edge present in the first RX_EDGE cycle is honoured.
- The gap counter runs only in IDLE. The period between command issues is POLL_GAP plus the transaction duration.
- If enable drops mid-transaction, the transaction completes normally.
- buttons_valid and rx_error are never asserted in the same cycle.
- All counters are 16 bits, compare with ==, and never wrap.

Optional Feature:
N64_LINE_SYNC_EN
- Defined: line_in passes through a two-flop synchronizer (both flops reset to 1) before edge detection and sampling. Response sample instants shift by +2 cycles relative to the pad.
- Undefined: line_in is used directly. The bench drives it synchronously to clk.

Test Plan:
- Reset values: reset high 3 cycles with enable=1, then low → all outputs zero, busy=0, first cmd_en exactly POLL_GAP cycles after reset release.
- Good poll: bench model of the writer (busy 10 cycles) plus a controller model replying 32'h8040_12FE in 400-cycle bit cells (0 = low 300 cycles, 1 = low 100 cycles), then a stop bit → buttons=32'h8040_12FE, a single buttons_valid pulse, rx_error never high.
- No reply: writer completes, line held high → rx_error pulse exactly RX_TIMEOUT cycles after RX_EDGE entry, buttons retains the previous value, next cmd_en follows POLL_GAP later.
- Reply truncated after 17 bits → rx_error pulse, buttons unchanged, no buttons_valid.
- Dead writer: writer_busy tied 0 → rx_error BUSY_TIMEOUT cycles after cmd_en, block returns to IDLE.
- enable low → no cmd_en for 3×POLL_GAP cycles. Reset asserted during RX_SAMPLE → busy=0 and buttons=0 on the next cycle.

Source files
------------

// File: rtl/n64_poll_sequencer.sv
// N64 controller-port poll sequencer: issues the poll command, then receives and decodes the 32-bit reply.
// Optional N64_LINE_SYNC_EN adds a two-flop synchronizer on line_in (sample instants shift +2 cycles).
module n64_poll_sequencer #(
  parameter logic [15:0] POLL_GAP     = 16'd50000,
  parameter logic [7:0]  POLL_CMD     = 8'h01,
  parameter logic [15:0] BIT_CYCLES   = 16'd400,
  parameter logic [15:0] SAMPLE_POINT = 16'd200,
  parameter logic [15:0] RX_TIMEOUT   = 16'd1200,
  parameter logic [15:0] BUSY_TIMEOUT = 16'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [7:0]  cmd_byte,
  output logic        cmd_en,
  input  logic        writer_busy,
  input  logic        line_in,
  output logic [31:0] buttons,
  output logic        buttons_valid,
  output logic        rx_error,
  output logic        busy
);

  localparam int unsigned CW = 16;
  localparam int unsigned BW = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_RX_EDGE, S_RX_SAMPLE, S_DONE
  } state_t;

  // The sample instant has to fall inside one bit cell.
  if (SAMPLE_POINT >= BIT_CYCLES) begin : g_bad_sample_point
    $error("SAMPLE_POINT must be smaller than BIT_CYCLES");
  end

  state_t          state_q, state_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic [CW-1:0]   phase_q, phase_d;
  logic [CW-1:0]   bitcnt_q, bitcnt_d;
  logic [BW-1:0]   shift_q, shift_d;
  logic [BW-1:0]   buttons_q, buttons_d;
  logic            line_prev_q;
  logic            cmd_en_q, cmd_en_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            line_s;

`ifdef N64_LINE_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], line_in};
  end
  assign line_s = sync_q[1];
`else
  assign line_s = line_in;
`endif

  logic fall_c, gap_hit_c, busy_tmo_c, rx_tmo_c, sample_c;
  assign fall_c     = line_prev_q & ~line_s;
  assign gap_hit_c  = (gap_q == POLL_GAP - 16'd1);
  // Counter is preloaded to 1 on leaving ISSUE, so it counts cycles since cmd_en.
  assign busy_tmo_c = (tmo_q == BUSY_TIMEOUT - 16'd1);
  assign rx_tmo_c   = (tmo_q == RX_TIMEOUT - 16'd1);
  assign sample_c   = (phase_q == SAMPLE_POINT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath counters
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    phase_d  = phase_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    unique case (state_q)
      S_IDLE: begin
        if (!enable)        gap_d = '0;
        else if (gap_hit_c) begin
          state_d = S_ISSUE;
          gap_d   = '0;
        end else            gap_d = gap_q + 16'd1;
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
        tmo_d   = 16'd1;
      end
      S_WAIT_BUSY: begin
        if (writer_busy)     state_d = S_WAIT_DONE;
        else if (busy_tmo_c) state_d = S_IDLE;
        else                 tmo_d   = tmo_q + 16'd1;
      end
      S_WAIT_DONE: begin
        if (!writer_busy) begin
          state_d  = S_RX_EDGE;
          tmo_d    = '0;
          bitcnt_d = '0;
        end
      end
      S_RX_EDGE: begin
        if (fall_c) begin
          state_d = S_RX_SAMPLE;
          phase_d = '0;
        end else if (rx_tmo_c) state_d = S_IDLE;
        else                   tmo_d   = tmo_q + 16'd1;
      end
      S_RX_SAMPLE: begin
        phase_d = phase_q + 16'd1;
        if (sample_c) begin
          shift_d  = {shift_q[BW-2:0], line_s};
          bitcnt_d = bitcnt_q + 16'd1;
          if (bitcnt_d == CW'(BW)) state_d = S_DONE;
          else begin
            state_d = S_RX_EDGE;
            tmo_d   = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    cmd_en_d  = (state_d == S_ISSUE);
    busy_d    = (state_d != S_IDLE);
    valid_d   = (state_q == S_DONE);
    err_d     = ((state_q == S_WAIT_BUSY) && !writer_busy && busy_tmo_c) ||
                ((state_q == S_RX_EDGE) && !fall_c && rx_tmo_c);
    buttons_d = (state_q == S_DONE) ? shift_q : buttons_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q       <= '0;
      tmo_q       <= '0;
      phase_q     <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      buttons_q   <= '0;
      line_prev_q <= 1'b1;
      cmd_en_q    <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      phase_q     <= phase_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      line_prev_q <= line_s;
      cmd_en_q    <= cmd_en_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_byte      = POLL_CMD;
  assign cmd_en        = cmd_en_q;
  assign buttons       = buttons_q;
  assign buttons_valid = valid_q;
  assign rx_error      = err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_n64_poll_sequencer.sv
// Bench for n64_poll_sequencer: writer and controller models, transaction table, strobe scoreboard.
module tb_n64_poll_sequencer;

  localparam int unsigned P       = 700;
  localparam int unsigned T       = 1200;
  localparam int unsigned B       = 8;
  localparam int unsigned WR_BUSY = 10;
  localparam int unsigned EVT_MAX = 20000;

  logic        clk, reset, enable, writer_busy, line_in;
  logic [7:0]  cmd_byte;
  logic        cmd_en, buttons_valid, rx_error, busy;
  logic [31:0] buttons;

  n64_poll_sequencer #(
    .POLL_GAP(16'(P)), .POLL_CMD(8'h01), .BIT_CYCLES(16'd400),
    .SAMPLE_POINT(16'd200), .RX_TIMEOUT(16'(T)), .BUSY_TIMEOUT(16'(B))
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_byte(cmd_byte), .cmd_en(cmd_en),
    .writer_busy(writer_busy), .line_in(line_in), .buttons(buttons),
    .buttons_valid(buttons_valid), .rx_error(rx_error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    int          dly;
    bit          dead;
    bit          drop_en;
    logic        exp_err;
    logic [31:0] exp_btn;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] btn;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned evt_cnt = 0;
  int unsigned t_evt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Strobe monitor: every valid/error pulse consumes one scoreboard entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (buttons_valid === 1'b1 || rx_error === 1'b1) begin
      t_evt = cyc;
      evt_cnt++;
      check("strobes_exclusive", 32'(buttons_valid & rx_error), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b expected none", buttons_valid, rx_error);
      end else begin
        e = sb.pop_front();
        check("strobe_is_error", 32'(rx_error), 32'(e.err));
        check("buttons_at_strobe", buttons, e.btn);
      end
    end
  end

  task automatic wait_cmd(input int unsigned ref_cyc, input string nm, output int unsigned t_cmd);
    int unsigned n = 0;
    while (cmd_en !== 1'b1 && n < P + 100) begin
      @(negedge clk);
      n++;
    end
    t_cmd = cyc;
    if (cmd_en !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: cmd_en not seen within %0d cycles", nm, P + 100);
    end else begin
      check(nm, 32'(t_cmd - ref_cyc), 32'(P));
      check("cmd_byte", 32'(cmd_byte), 32'h01);
    end
  endtask

  task automatic run_writer(input bit dead, output int unsigned t_drop);
    if (!dead) begin
      writer_busy = 1'b1;
      repeat (WR_BUSY) @(negedge clk);
      writer_busy = 1'b0;
    end
    t_drop = cyc;
  endtask

  // Controller reply: 0 = low 300 / high 100, 1 = low 100 / high 300, then a stop bit.
  task automatic send_bits(input logic [31:0] w, input int nbits, input int dly, input bit restore_en);
    int lo;
    repeat (dly) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (restore_en && i == 16) enable = 1'b1;
      lo = w[31-i] ? 100 : 300;
      line_in = 1'b0;
      repeat (lo) @(negedge clk);
      line_in = 1'b1;
      repeat (400 - lo) @(negedge clk);
    end
    if (nbits == 32) begin
      line_in = 1'b0;
      repeat (100) @(negedge clk);
      line_in = 1'b1;
      repeat (100) @(negedge clk);
    end
  endtask

  task automatic wait_evt(input int unsigned evt0, input string nm);
    int unsigned n = 0;
    while (evt_cnt == evt0 && n < EVT_MAX) begin
      @(negedge clk);
      n++;
    end
    if (evt_cnt == evt0) begin
      checks++;
      errors++;
      $display("FAIL %s: no strobe within %0d cycles", nm, EVT_MAX);
      sb.delete();
    end
  endtask

  vec_t vecs [6];

  initial begin
    int unsigned t_ref, t_cmd, t_drop, evt0, n_cmd;

    vecs[0] = '{32'h8040_12FE, 32, 20, 1'b0, 1'b0, 1'b0, 32'h8040_12FE};
    vecs[1] = '{32'h0000_0000,  0,  0, 1'b0, 1'b0, 1'b1, 32'h8040_12FE};
    vecs[2] = '{32'hFFFF_0000, 32,  1, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000};
    vecs[3] = '{32'h1234_5678, 17, 20, 1'b0, 1'b0, 1'b1, 32'hFFFF_0000};
    vecs[4] = '{32'h0000_0000,  0,  0, 1'b1, 1'b0, 1'b1, 32'hFFFF_0000};
    vecs[5] = '{32'h0000_0001, 32,  5, 1'b0, 1'b1, 1'b0, 32'h0000_0001};

    reset = 1'b1; enable = 1'b1; writer_busy = 1'b0; line_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_buttons", buttons, 32'd0);
    check("reset_strobes", {28'd0, cmd_en, buttons_valid, rx_error, busy}, 32'd0);
    reset = 1'b0;
    t_ref = cyc;

    for (int i = 0; i < 6; i++) begin
      wait_cmd(t_ref, "gap_to_cmd_en", t_cmd);
      evt0 = evt_cnt;
      sb.push_back('{vecs[i].exp_err, vecs[i].exp_btn});
      if (vecs[i].drop_en) enable = 1'b0;
      run_writer(vecs[i].dead, t_drop);
      send_bits(vecs[i].word, vecs[i].nbits, vecs[i].dly, vecs[i].drop_en);
      wait_evt(evt0, "strobe_wait");
      if (vecs[i].dead)
        check("busy_timeout_cycles", 32'(t_evt - t_cmd), 32'(B));
      else if (vecs[i].nbits == 0)
        check("rx_timeout_cycles", 32'(t_evt - t_drop), 32'(T + 1));
      check("busy_after_txn", 32'(busy), 32'd0);
      t_ref = t_evt;
    end

    // Polling disabled: no command for three gaps, then exactly one gap after re-enable.
    enable = 1'b0;
    n_cmd = 0;
    repeat (3 * P) begin
      @(negedge clk);
      if (cmd_en === 1'b1) n_cmd++;
    end
    check("no_cmd_while_disabled", 32'(n_cmd), 32'd0);
    enable = 1'b1;
    t_ref = cyc;
    wait_cmd(t_ref, "gap_after_enable", t_cmd);

    // Reset while a bit is being sampled.
    run_writer(1'b0, t_drop);
    repeat (20) @(negedge clk);
    line_in = 1'b0;
    repeat (50) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("busy_after_reset", 32'(busy), 32'd0);
    check("buttons_after_reset", buttons, 32'd0);
    line_in = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_after_reset", {30'd0, busy, cmd_en}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
